// File: rtl/multi_lane_fifo_pkg.sv
// Shared helpers for the multi-lane ID->EX FIFO: pointer/count widths and the
// contiguous-lane prefix count used for both enqueue and dequeue acceptance.
package multi_lane_fifo_pkg;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Lane 1 only counts when lane 0 is also set; lanes beyond the configured count are ignored.
   function automatic logic [1:0] prefix_count(input logic [1:0] v, input int lanes);
      if (!v[0]) return 2'd0;
      if ((lanes > 1) && v[1]) return 2'd2;
      return 2'd1;
   endfunction

endpackage

// File: rtl/multi_lane_fifo_if.sv
// Bundle between ID (producer), EX (consumer) and the multi-lane FIFO.
// The FIFO side uses the slave modport; the pipeline side uses master.
interface multi_lane_fifo_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   parameter int LANES = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   // Handshake: an enqueue lane transfers when enq_ready is high and it belongs to the
   // contiguous valid prefix starting at lane 0; a dequeue lane transfers when deq_pop and
   // deq_valid are both high and it belongs to the contiguous prefix. flush overrides both.
   logic                   flush;
   logic [LANES-1:0]       enq_valid;
   logic [LANES*WIDTH-1:0] enq_data;
   logic                   enq_ready;
   logic [LANES-1:0]       deq_valid;
   logic [LANES*WIDTH-1:0] deq_data;
   logic [LANES-1:0]       deq_pop;
   logic [CW-1:0]          count;
   logic                   full;
   logic                   empty;
   logic                   almost_full;

   modport master (
      output flush, enq_valid, enq_data, deq_pop,
      input  enq_ready, deq_valid, deq_data, count, full, empty, almost_full
   );

   modport slave (
      input  flush, enq_valid, enq_data, deq_pop,
      output enq_ready, deq_valid, deq_data, count, full, empty, almost_full
   );

endinterface

// File: rtl/multi_lane_fifo_ram.sv
// DEPTH x WIDTH storage with LANES write ports at wbase+i and LANES asynchronous
// read ports at rbase+i; addresses wrap modulo DEPTH. Contents are not reset.
module multi_lane_fifo_ram
   import multi_lane_fifo_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8,
   parameter int LANES = 2,
   parameter int PW    = ptr_w(DEPTH)
) (
   input  logic                   clk,
   input  logic [LANES-1:0]       we,
   input  logic [PW-1:0]          wbase,
   input  logic [LANES*WIDTH-1:0] wdata,
   input  logic [PW-1:0]          rbase,
   output logic [LANES*WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) mem_q[wbase + PW'(i)] <= wdata[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < LANES; i++) begin
         rdata[i*WIDTH +: WIDTH] = mem_q[rbase + PW'(i)];
      end
   end

endmodule

// File: rtl/multi_lane_fifo.sv
// Multi-lane first-word-fall-through FIFO decoupling ID from EX, with flush.
// Optional same-cycle forwarding through an empty FIFO: MULTI_LANE_FIFO_BYPASS_EN.
module multi_lane_fifo
   import multi_lane_fifo_pkg::*;
#(
   parameter int WIDTH        = 64,
   parameter int DEPTH        = 8,
   parameter int LANES        = 2,
   parameter int AFULL_THRESH = DEPTH - 2
) (
   input logic               clk,
   input logic               rst,
   multi_lane_fifo_if.slave  bus
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0]          head_q, head_d;
   logic [PW-1:0]          tail_q, tail_d;
   logic [CW-1:0]          count_q, count_d;
   logic [1:0]             n_enq, n_deq;
   logic [LANES-1:0]       enq_acc;
   logic [LANES-1:0]       we;
   logic                   bypass;
   logic [LANES*WIDTH-1:0] ram_rdata;

   multi_lane_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LANES (LANES),
      .PW    (PW)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .wbase (tail_q),
      .wdata (bus.enq_data),
      .rbase (head_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      // Registered count only, so deq_pop never reaches enq_ready combinationally.
      bus.enq_ready = (count_q <= CW'(DEPTH - LANES));
      n_enq = bus.enq_ready ? prefix_count(2'(bus.enq_valid), LANES) : 2'd0;
      enq_acc = '0;
      for (int i = 0; i < LANES; i++) enq_acc[i] = (n_enq > 2'(i));

`ifdef MULTI_LANE_FIFO_BYPASS_EN
      bypass = (count_q == '0) && !bus.flush;
`else
      bypass = 1'b0;
`endif

      bus.deq_valid = '0;
      for (int i = 0; i < LANES; i++) bus.deq_valid[i] = (count_q > CW'(i));
      bus.deq_data = ram_rdata;
`ifdef MULTI_LANE_FIFO_BYPASS_EN
      if (bypass) begin
         bus.deq_valid = enq_acc;
         bus.deq_data  = bus.enq_data;
      end
`endif

      n_deq = prefix_count(2'(bus.deq_pop & bus.deq_valid), LANES);

      // Forwarded lanes that are popped this cycle never touch storage; head skips past them.
      we = '0;
      for (int i = 0; i < LANES; i++) begin
         we[i] = enq_acc[i] && !bus.flush && !(bypass && (n_deq > 2'(i)));
      end

      head_d  = head_q + PW'(n_deq);
      tail_d  = tail_q + PW'(n_enq);
      count_d = count_q + CW'(n_enq) - CW'(n_deq);
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end

      bus.count       = count_q;
      bus.full        = (count_q == CW'(DEPTH));
      bus.empty       = (count_q == '0);
      bus.almost_full = (count_q >= CW'(AFULL_THRESH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_multi_lane_fifo.sv
// Directed bench for multi_lane_fifo (WIDTH=8, DEPTH=8, LANES=2); expectations follow
// the build: MULTI_LANE_FIFO_BYPASS_EN selects the zero-latency variant of the last step.
module tb_multi_lane_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int LANES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [WIDTH-1:0] exp_q[$];

   multi_lane_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) bus ();

   multi_lane_fifo #(
      .WIDTH        (WIDTH),
      .DEPTH        (DEPTH),
      .LANES        (LANES),
      .AFULL_THRESH (DEPTH - 2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] ev, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] pop, input logic fl);
      bus.enq_valid = ev;
      bus.enq_data  = {d1, d0};
      bus.deq_pop   = pop;
      bus.flush     = fl;
      #1;
   endtask

   task automatic idle();
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic [7:0] d0, d1;
      idle();
      tick();
      tick();

      // reset state
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_afull", 32'(bus.almost_full), 0);
      chk("rst_enq_ready", 32'(bus.enq_ready), 1);
      chk("rst_deq_valid", 32'(bus.deq_valid), 0);
      rst = 1'b0;
      tick();

      // fill with pairs, no pops
      for (int k = 0; k < 4; k++) begin
         d0 = 8'h11 + 8'(8'h22 * k);
         d1 = d0 + 8'h11;
         exp_q.push_back(d0);
         exp_q.push_back(d1);
         drive(2'b11, d0, d1, 2'b00, 1'b0);
         tick();
         chk("fill_count", 32'(bus.count), 32'(2 * (k + 1)));
         chk("fill_afull", 32'(bus.almost_full), (k >= 2) ? 1 : 0);
         chk("fill_enq_ready", 32'(bus.enq_ready), (k < 3) ? 1 : 0);
      end
      chk("fill_full", 32'(bus.full), 1);

      // enqueue attempt while full is rejected
      drive(2'b11, 8'h99, 8'h9A, 2'b00, 1'b0);
      tick();
      chk("full_reject_count", 32'(bus.count), 8);

      // drain in order
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
         chk("drain_valid", 32'(bus.deq_valid), 32'h3);
         chk("drain_lane0", 32'(bus.deq_data[7:0]), 32'(exp_q.pop_front()));
         chk("drain_lane1", 32'(bus.deq_data[15:8]), 32'(exp_q.pop_front()));
         tick();
      end
      chk("drain_count", 32'(bus.count), 0);
      chk("drain_empty", 32'(bus.empty), 1);

      // build count=7 with values 1..7
      drive(2'b11, 8'h01, 8'h02, 2'b00, 1'b0); tick();
      drive(2'b11, 8'h03, 8'h04, 2'b00, 1'b0); tick();
      drive(2'b11, 8'h05, 8'h06, 2'b00, 1'b0); tick();
      drive(2'b01, 8'h07, 8'h00, 2'b00, 1'b0); tick();
      chk("seven_count", 32'(bus.count), 7);

      // simultaneous pop 2 / enqueue 2 at count 7: enqueue refused
      drive(2'b11, 8'hC1, 8'hC2, 2'b11, 1'b0);
      chk("simul_enq_ready", 32'(bus.enq_ready), 0);
      chk("simul_data", 32'(bus.deq_data), 32'h0201);
      tick();
      chk("simul_count", 32'(bus.count), 5);
      chk("simul_head", 32'(bus.deq_data[7:0]), 32'h03);

      drive(2'b00, 8'h00, 8'h00, 2'b11, 1'b0); tick();
      chk("three_count", 32'(bus.count), 3);

      // lane 1 without lane 0 is ignored on both sides
      drive(2'b10, 8'hD0, 8'hD1, 2'b10, 1'b0); tick();
      chk("illegal_count", 32'(bus.count), 3);
      chk("illegal_data", 32'(bus.deq_data), 32'h0605);

      drive(2'b00, 8'h00, 8'h00, 2'b11, 1'b0); tick();
      chk("tail_entry", 32'(bus.deq_data[7:0]), 32'h07);
      drive(2'b00, 8'h00, 8'h00, 2'b01, 1'b0); tick();
      chk("empty_at_7", 32'(bus.count), 0);

      // wrap: head=tail=7, pair lands in slots 7 and 0
      drive(2'b11, 8'h0A, 8'h0B, 2'b00, 1'b0); tick();
      chk("wrap_valid", 32'(bus.deq_valid), 32'h3);
      chk("wrap_data", 32'(bus.deq_data), 32'h0B0A);
      chk("wrap_count", 32'(bus.count), 2);
      drive(2'b00, 8'h00, 8'h00, 2'b11, 1'b0); tick();

      // flush with enqueue and pop in the same cycle
      drive(2'b11, 8'h21, 8'h22, 2'b00, 1'b0); tick();
      drive(2'b11, 8'h23, 8'h24, 2'b00, 1'b0); tick();
      drive(2'b01, 8'h25, 8'h00, 2'b00, 1'b0); tick();
      chk("preflush_count", 32'(bus.count), 5);
      drive(2'b11, 8'hEE, 8'hFF, 2'b01, 1'b1); tick();
      chk("flush_count", 32'(bus.count), 0);
      chk("flush_empty", 32'(bus.empty), 1);
      chk("flush_valid", 32'(bus.deq_valid), 0);
      drive(2'b01, 8'h42, 8'h00, 2'b00, 1'b0); tick();
      chk("postflush_count", 32'(bus.count), 1);
      chk("postflush_data", 32'(bus.deq_data[7:0]), 32'h42);
      drive(2'b00, 8'h00, 8'h00, 2'b01, 1'b0); tick();

      // enqueue and pop together on an empty FIFO
      drive(2'b01, 8'h05, 8'h00, 2'b01, 1'b0);
`ifdef MULTI_LANE_FIFO_BYPASS_EN
      chk("bypass_valid", 32'(bus.deq_valid), 32'h1);
      chk("bypass_data", 32'(bus.deq_data[7:0]), 32'h05);
      tick();
      idle();
      chk("bypass_count", 32'(bus.count), 0);
`else
      chk("nobypass_valid", 32'(bus.deq_valid), 0);
      tick();
      idle();
      chk("nobypass_count", 32'(bus.count), 1);
      chk("nobypass_data", 32'(bus.deq_data[7:0]), 32'h05);
`endif

      // reset wins over flush
      rst = 1'b1;
      drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
      tick();
      chk("rst_over_flush_count", 32'(bus.count), 0);
      chk("rst_over_flush_ready", 32'(bus.enq_ready), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
